seq_divider: RTL and testbench



---
 rtl/seq_divider.sv | 108 ++++++++++
 tb/tb_seq_divider.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider: sequential restoring divider, WIDTH steps per operation with a one-cycle done pulse.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (magnitude divide plus sign fix-up).
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] p_q, p_d, q_q, q_d, d_q, d_d, n_q, n_d;
  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
  logic [WIDTH-1:0] a_mag, b_mag, diff, p_nx, q_nx, q_fin, r_fin;
  logic [WIDTH:0] p_sh;
  logic dbz_q, dbz_d, accept, last, ge, dz;
  assign accept = start && state_q != RUN;
  assign last = cnt_q == CW'(WIDTH - 1);
  assign dz = d_q == '0;
  assign p_sh = {p_q, q_q[WIDTH-1]};
  assign ge = p_sh >= {1'b0, d_q};
  // Compare is WIDTH+1 bits; when ge the true difference is below the divisor, so WIDTH bits hold it exactly.
  assign diff = p_sh[WIDTH-1:0] - d_q;
  assign p_nx = ge ? diff : p_sh[WIDTH-1:0];
  assign q_nx = {q_q[WIDTH-2:0], ge};
`ifdef SEQ_DIVIDER_SIGNED_EN
  logic sd_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) sd_q <= 1'b0;
    else if (accept) sd_q <= divisor[WIDTH-1];
  assign a_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign b_mag = divisor[WIDTH-1] ? -divisor : divisor;
  assign q_fin = dz ? '1 : (n_q[WIDTH-1] ^ sd_q) ? -q_nx : q_nx;
  assign r_fin = dz ? n_q : n_q[WIDTH-1] ? -p_nx : p_nx;
`else
  assign a_mag = dividend;
  assign b_mag = divisor;
  assign q_fin = dz ? '1 : q_nx;
  assign r_fin = dz ? n_q : p_nx;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    p_d = p_q;
    q_d = q_q;
    d_d = d_q;
    n_d = n_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dbz_d = dbz_q;
    if (accept) begin
      state_d = RUN;
      cnt_d = '0;
      p_d = '0;
      q_d = a_mag;
      d_d = b_mag;
      n_d = dividend;
    end else if (state_q == RUN) begin
      cnt_d = cnt_q + CW'(1);
      p_d = p_nx;
      q_d = q_nx;
      if (last) begin
        state_d = DONE;
        quo_d = q_fin;
        rem_d = r_fin;
        dbz_d = dz;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      p_q <= '0;
      q_q <= '0;
      d_q <= '0;
      n_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      p_q <= p_d;
      q_q <= q_d;
      d_q <= d_d;
      n_q <= n_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dbz_q <= dbz_d;
    end
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign quotient = quo_q;
  assign remainder = rem_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed scenario tests for seq_divider at WIDTH=4.
module tb_seq_divider;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [3:0] dividend = '0, divisor = '0;
  logic busy, done, div_by_zero;
  logic [3:0] quotient, remainder;
  int checks = 0, failures = 0;
  seq_divider #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic op(input logic [3:0] a, input logic [3:0] b, output int lat);
    start = 1'b1;
    dividend = a;
    divisor = b;
    tick;
    start = 1'b0;
    dividend = 4'($urandom);
    divisor = 4'($urandom);
    lat = -1;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      tick;
      if (done) lat = i;
    end
  endtask
  task automatic test_reset;
    #2;
    checks += 5;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    if (quotient !== 4'd0) begin failures++; $display("FAIL reset_quo got=%0d exp=0", quotient); end
    if (remainder !== 4'd0) begin failures++; $display("FAIL reset_rem got=%0d exp=0", remainder); end
    if (div_by_zero !== 1'b0) begin failures++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
    tick;
    rst = 1'b0;
    tick;
  endtask
  task automatic test_basic;
    start = 1'b1;
    dividend = 4'd13;
    divisor = 4'd3;
    tick;
    start = 1'b0;
    dividend = 4'd0;
    divisor = 4'd0;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if ({busy, done} !== 2'b10) begin failures++; $display("FAIL basic_busy_T+%0d got=%b exp=10", i, {busy, done}); end
      tick;
    end
    checks += 4;
    if ({busy, done} !== 2'b01) begin failures++; $display("FAIL basic_done got=%b exp=01", {busy, done}); end
    if (quotient !== 4'd4) begin failures++; $display("FAIL basic_quo got=%0d exp=4", quotient); end
    if (remainder !== 4'd1) begin failures++; $display("FAIL basic_rem got=%0d exp=1", remainder); end
    if (div_by_zero !== 1'b0) begin failures++; $display("FAIL basic_dbz got=%b exp=0", div_by_zero); end
    tick;
    checks += 2;
    if ({busy, done} !== 2'b00) begin failures++; $display("FAIL basic_pulse got=%b exp=00", {busy, done}); end
    if (quotient !== 4'd4) begin failures++; $display("FAIL basic_hold got=%0d exp=4", quotient); end
  endtask
  task automatic test_back_to_back;
    int lat;
    op(4'd15, 4'd1, lat);
    checks += 3;
    if (lat !== 4) begin failures++; $display("FAIL b2b_lat1 got=%0d exp=4", lat); end
    if (quotient !== 4'd15) begin failures++; $display("FAIL b2b_quo1 got=%0d exp=15", quotient); end
    if (remainder !== 4'd0) begin failures++; $display("FAIL b2b_rem1 got=%0d exp=0", remainder); end
    op(4'd2, 4'd9, lat);
    checks += 3;
    if (lat !== 4) begin failures++; $display("FAIL b2b_lat2 got=%0d exp=4", lat); end
    if (quotient !== 4'd0) begin failures++; $display("FAIL b2b_quo2 got=%0d exp=0", quotient); end
    if (remainder !== 4'd2) begin failures++; $display("FAIL b2b_rem2 got=%0d exp=2", remainder); end
  endtask
  task automatic test_div_zero;
    int lat;
    op(4'd7, 4'd0, lat);
    checks += 4;
    if (lat !== 4) begin failures++; $display("FAIL dz_lat got=%0d exp=4", lat); end
    if (quotient !== 4'd15) begin failures++; $display("FAIL dz_quo got=%0d exp=15", quotient); end
    if (remainder !== 4'd7) begin failures++; $display("FAIL dz_rem got=%0d exp=7", remainder); end
    if (div_by_zero !== 1'b1) begin failures++; $display("FAIL dz_flag got=%b exp=1", div_by_zero); end
    tick;
    checks++;
    if (div_by_zero !== 1'b1) begin failures++; $display("FAIL dz_hold got=%b exp=1", div_by_zero); end
    op(4'd6, 4'd2, lat);
    checks += 4;
    if (lat !== 4) begin failures++; $display("FAIL dz_next_lat got=%0d exp=4", lat); end
    if (quotient !== 4'd3) begin failures++; $display("FAIL dz_next_quo got=%0d exp=3", quotient); end
    if (remainder !== 4'd0) begin failures++; $display("FAIL dz_next_rem got=%0d exp=0", remainder); end
    if (div_by_zero !== 1'b0) begin failures++; $display("FAIL dz_next_flag got=%b exp=0", div_by_zero); end
    tick;
  endtask
  task automatic test_ignore_start;
    int dones;
    start = 1'b1;
    dividend = 4'd12;
    divisor = 4'd5;
    tick;
    start = 1'b0;
    tick;
    start = 1'b1;
    dividend = 4'd9;
    divisor = 4'd3;
    tick;
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) dones++;
      tick;
    end
    checks += 3;
    if (dones !== 1) begin failures++; $display("FAIL ign_dones got=%0d exp=1", dones); end
    if (quotient !== 4'd2) begin failures++; $display("FAIL ign_quo got=%0d exp=2", quotient); end
    if (remainder !== 4'd2) begin failures++; $display("FAIL ign_rem got=%0d exp=2", remainder); end
  endtask
  task automatic test_async_reset;
    int dones, lat;
    start = 1'b1;
    dividend = 4'd11;
    divisor = 4'd2;
    tick;
    start = 1'b0;
    tick;
    #2 rst = 1'b1;
    #1;
    checks += 5;
    if (busy !== 1'b0) begin failures++; $display("FAIL arst_busy got=%b exp=0", busy); end
    if (done !== 1'b0) begin failures++; $display("FAIL arst_done got=%b exp=0", done); end
    if (quotient !== 4'd0) begin failures++; $display("FAIL arst_quo got=%0d exp=0", quotient); end
    if (remainder !== 4'd0) begin failures++; $display("FAIL arst_rem got=%0d exp=0", remainder); end
    if (div_by_zero !== 1'b0) begin failures++; $display("FAIL arst_dbz got=%b exp=0", div_by_zero); end
    tick;
    #2 rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (done) dones++;
    end
    checks++;
    if (dones !== 0) begin failures++; $display("FAIL arst_stray_done got=%0d exp=0", dones); end
    op(4'd11, 4'd2, lat);
    checks += 3;
    if (lat !== 4) begin failures++; $display("FAIL arst_lat got=%0d exp=4", lat); end
    if (quotient !== 4'd5) begin failures++; $display("FAIL arst_quo2 got=%0d exp=5", quotient); end
    if (remainder !== 4'd1) begin failures++; $display("FAIL arst_rem2 got=%0d exp=1", remainder); end
    tick;
  endtask
  task automatic test_signed;
    int lat;
    op(4'b1001, 4'd2, lat);
    checks += 3;
    if (lat !== 4) begin failures++; $display("FAIL s_lat got=%0d exp=4", lat); end
    if (quotient !== 4'b1101) begin failures++; $display("FAIL s_m7d2_quo got=%b exp=1101", quotient); end
    if (remainder !== 4'b1111) begin failures++; $display("FAIL s_m7d2_rem got=%b exp=1111", remainder); end
    op(4'b1000, 4'b1111, lat);
    checks += 2;
    if (quotient !== 4'b1000) begin failures++; $display("FAIL s_m8dm1_quo got=%b exp=1000", quotient); end
    if (remainder !== 4'b0000) begin failures++; $display("FAIL s_m8dm1_rem got=%b exp=0000", remainder); end
    op(4'd7, 4'b1110, lat);
    checks += 2;
    if (quotient !== 4'b1101) begin failures++; $display("FAIL s_7dm2_quo got=%b exp=1101", quotient); end
    if (remainder !== 4'b0001) begin failures++; $display("FAIL s_7dm2_rem got=%b exp=0001", remainder); end
    op(4'b1010, 4'd0, lat);
    checks += 3;
    if (quotient !== 4'b1111) begin failures++; $display("FAIL s_dz_quo got=%b exp=1111", quotient); end
    if (remainder !== 4'b1010) begin failures++; $display("FAIL s_dz_rem got=%b exp=1010", remainder); end
    if (div_by_zero !== 1'b1) begin failures++; $display("FAIL s_dz_flag got=%b exp=1", div_by_zero); end
    tick;
  endtask
  initial begin
    test_reset;
`ifdef SEQ_DIVIDER_SIGNED_EN
    test_signed;
`else
    test_basic;
    test_back_to_back;
    test_div_zero;
    test_ignore_start;
    test_async_reset;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
